key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 138 +++++++++++++
 tb/tb_key_debounce.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Multi-key front end: synchronises and debounces active-low buttons and
// produces level, press/release pulses and long-press with auto-repeat per key.
module key_debounce #(
    parameter int KEY_NUM         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_res_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_repeat
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        LP_IDLE   = 2'd0,
        LP_HOLD   = 2'd1,
        LP_REPEAT = 2'd2
    } lp_state_t;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        logic              sync_q1;
        logic              sync_q2;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              repeat_q;
        logic [DB_W-1:0]   db_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [REP_W-1:0]  rep_cnt;
        lp_state_t         lp_state;
        logic              db_done;
        logic              press_now;
        logic              release_now;

        // The level flips on the cycle the disagreement count would reach DEBOUNCE_CYCLES.
        assign db_done     = (sync_q2 != level_q) && (db_cnt == DB_LAST);
        assign press_now   = db_done && !sync_q2;
        assign release_now = db_done && sync_q2;

        always_ff @(posedge sys_clk or negedge sys_res_n) begin
            if (!sys_res_n) begin
                sync_q1 <= 1'b1;
                sync_q2 <= 1'b1;
            end else begin
                sync_q1 <= key_in[i];
                sync_q2 <= sync_q1;
            end
        end

        always_ff @(posedge sys_clk or negedge sys_res_n) begin
            if (!sys_res_n) begin
                level_q   <= 1'b1;
                db_cnt    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= press_now;
                release_q <= release_now;
                if (sync_q2 == level_q) begin
                    db_cnt <= '0;
                end else if (db_done) begin
                    level_q <= sync_q2;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // Release wins over everything so no long/repeat can coincide with it.
        always_ff @(posedge sys_clk or negedge sys_res_n) begin
            if (!sys_res_n) begin
                lp_state <= LP_IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
            end else begin
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
                if (release_now) begin
                    lp_state <= LP_IDLE;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end else begin
                    case (lp_state)
                        LP_IDLE: begin
                            if (press_now) begin
                                lp_state <= LP_HOLD;
                                hold_cnt <= '0;
                            end
                        end
                        LP_HOLD: begin
                            if (hold_cnt == HOLD_LAST) begin
                                long_q   <= 1'b1;
                                lp_state <= LP_REPEAT;
                                hold_cnt <= '0;
                                rep_cnt  <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        LP_REPEAT: begin
                            if (rep_cnt == REP_LAST) begin
                                repeat_q <= 1'b1;
                                rep_cnt  <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                        default: lp_state <= LP_IDLE;
                    endcase
                end
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
        assign key_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: expected events are queued as stimulus is driven and
// matched against every non-zero event vector the DUT emits.
module tb_key_debounce;

    localparam int KEY_NUM = 4;
    localparam int DB      = 8;
    localparam int HOLD    = 40;
    localparam int REP     = 10;
    localparam int LAT     = 2 + DB;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    logic               sys_clk;
    logic               sys_res_n;
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_level;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;
    logic [KEY_NUM-1:0] key_repeat;

    int unsigned cyc;
    int          n_checks;
    int          n_pass;
    logic [21:0] exp_q[$];

    key_debounce #(
        .KEY_NUM        (KEY_NUM),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_res_n  (sys_res_n),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .key_repeat (key_repeat)
    );

    // Clock and cycle counter: after posedge n, cyc == n.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_ev(input int unsigned c, input logic [1:0] kind, input logic [3:0] mask);
        exp_q.push_back({c[15:0], kind, mask});
    endtask

    // Scoreboard: each non-zero event vector is tagged with cycle and kind.
    always @(negedge sys_clk) begin
        logic [KEY_NUM-1:0] v[4];
        logic [21:0]        obs;
        logic [31:0]        c;
        v[0] = key_press;
        v[1] = key_release;
        v[2] = key_long;
        v[3] = key_repeat;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            if (v[k] != '0) begin
                obs = {c[15:0], 2'(k), v[k]};
                if (exp_q.size() == 0) check("unexpected_event", {10'd0, obs}, 32'd0);
                else check("event", {10'd0, obs}, {10'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int unsigned t;
        int unsigned p;
        int unsigned r;
        int          gap;
        n_checks  = 0;
        n_pass    = 0;
        sys_res_n = 1'b0;
        key_in    = '1;

        step(3);
        check("reset_level", 32'(key_level), 32'hF);
        check("reset_press", 32'(key_press), 32'h0);
        check("reset_release", 32'(key_release), 32'h0);
        check("reset_long", 32'(key_long), 32'h0);
        check("reset_repeat", 32'(key_repeat), 32'h0);
        sys_res_n = 1'b1;
        step(10);

        // Clean press on key 0, released well before the hold time.
        t = cyc;
        expect_ev(t + LAT, EV_PRESS, 4'b0001);
        key_in[0] = 1'b0;
        step(LAT - 1);
        check("clean_level_before", 32'(key_level), 32'hF);
        step(1);
        check("clean_level_after", 32'(key_level), 32'hE);
        step(2);
        t = cyc;
        expect_ev(t + LAT, EV_RELEASE, 4'b0001);
        key_in[0] = 1'b1;
        step(LAT + 5);
        check("clean_released", 32'(key_level), 32'hF);

        // Bounce into press on key 1: toggles every 3 cycles, final edge low.
        t = cyc;
        expect_ev(t + 30 + LAT, EV_PRESS, 4'b0010);
        for (int e = 0; e <= 10; e++) begin
            key_in[1] = (e % 2 == 1);
            if (e < 10) step(3);
        end
        step(LAT + 2);
        p = cyc - 2;
        check("bounce_level", 32'(key_level), 32'hD);
        // Random-gap bounce on release, always short of the debounce window.
        for (int e = 0; e < 5; e++) begin
            key_in[1] = (e % 2 == 0);
            if (e < 4) begin
                gap = $urandom_range(1, 5);
                step(gap);
            end
        end
        expect_ev(cyc + LAT, EV_RELEASE, 4'b0010);
        check("bounce_short_of_hold", 32'(cyc + LAT < p + HOLD), 32'd1);
        step(LAT + 5);

        // Long press with repeat on key 2; release lands exactly on a repeat slot.
        t = cyc;
        p = t + LAT;
        expect_ev(p, EV_PRESS, 4'b0100);
        expect_ev(p + HOLD, EV_LONG, 4'b0100);
        expect_ev(p + HOLD + REP, EV_REPEAT, 4'b0100);
        expect_ev(p + HOLD + 2 * REP, EV_REPEAT, 4'b0100);
        expect_ev(p + HOLD + 3 * REP, EV_REPEAT, 4'b0100);
        expect_ev(p + 80, EV_RELEASE, 4'b0100);
        key_in[2] = 1'b0;
        step(LAT + 70);
        key_in[2] = 1'b1;
        step(LAT + 30);
        check("long_released", 32'(key_level), 32'hF);

        // Short press on key 3: press and release 20 cycles apart, no long.
        t = cyc;
        expect_ev(t + LAT, EV_PRESS, 4'b1000);
        expect_ev(t + LAT + 20, EV_RELEASE, 4'b1000);
        key_in[3] = 1'b0;
        step(20);
        check("short_level_held", 32'(key_level), 32'h7);
        key_in[3] = 1'b1;
        step(HOLD + 20);

        // Simultaneous press and release on keys 0 and 3.
        t = cyc;
        expect_ev(t + LAT, EV_PRESS, 4'b1001);
        expect_ev(t + LAT + 20, EV_RELEASE, 4'b1001);
        key_in = 4'b0110;
        step(20);
        check("simul_level", 32'(key_level), 32'h6);
        key_in = 4'b1111;
        step(LAT + 10);

        // Reset mid-hold on key 0; the still-held key is re-detected as a press.
        t = cyc;
        p = t + LAT;
        expect_ev(p, EV_PRESS, 4'b0001);
        key_in[0] = 1'b0;
        step(LAT + 25);
        sys_res_n = 1'b0;
        #1;
        check("rst_level", 32'(key_level), 32'hF);
        check("rst_events", 32'({key_press, key_release, key_long, key_repeat}), 32'h0);
        step(5);
        sys_res_n = 1'b1;
        r = cyc;
        expect_ev(r + LAT, EV_PRESS, 4'b0001);
        expect_ev(r + LAT + HOLD, EV_LONG, 4'b0001);
        expect_ev(r + LAT + 45, EV_RELEASE, 4'b0001);
        step(LAT - 1);
        check("rst_level_pre_press", 32'(key_level), 32'hF);
        step(1);
        check("rst_level_press", 32'(key_level), 32'hE);
        step(35);
        key_in[0] = 1'b1;
        step(LAT + 30);

        check("final_level", 32'(key_level), 32'hF);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
